regfile_mp_sb: RTL and testbench

Parametrised successor of the core integer register file. Two write ports and two combinational read ports, with register 0 hardwired to zero. Adds a per-register busy scoreboard that is set at issue and cleared at writeback, so the decode stage can detect RAW hazards. Sits between decode (read, issue) and writeback (two retire lanes).

---
 rtl/regfile_mp_sb.sv | 166 ++++++++++++++++
 tb/tb_regfile_mp_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//
// Integer register file with two write lanes, two combinational read ports
// and a per-register busy scoreboard for RAW hazard detection.
//
//   * Register 0 reads as zero and is never written.
//   * Lane 1 wins a same-address write collision.
//   * A register is marked busy when an instruction targeting it issues
//     (iss_valid/iss_rd) and cleared when either lane writes it back. When
//     issue and writeback hit the same register on the same edge, the new
//     issue wins and the register stays busy.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   Read ports forward same-cycle write data (lane 1 before lane 0). A
//   forwarded register reads not-busy unless it is being re-issued in the
//   same cycle. Without the macro, reads return registered state only.
//
// Ports:
//   clk              clock, all state changes on its rising edge
//   rst              asynchronous reset, active-high
//   we0/wa0/wd0      write lane 0: enable, address, data
//   we1/wa1/wd1      write lane 1 (priority): enable, address, data
//   iss_valid/iss_rd issue strobe and destination register (sets busy)
//   ra1/ra2          read addresses
//   rd1/rd2          read data (combinational)
//   busy1/busy2      pending-write flag for ra1/ra2
//   hazard           busy1 | busy2
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            busy;
  } rd_port_t;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // A lane only counts as writing when it targets a real register; writes
  // to x0 neither store data nor retire a scoreboard entry.
  logic wr0;
  logic wr1;
  logic iss_set;

  assign wr0     = we0 && (wa0 != '0);
  assign wr1     = we1 && (wa1 != '0);
  assign iss_set = iss_valid && (iss_rd != '0);

  // -------------------------------------------------------------------------
  // Next-state computation
  // -------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // earlier overrides; that ordering is what gives lane 1 and issue priority.
  always_comb begin
    // NOTE: every output of this block is given a full default first, so no
    // path can leave a value unassigned and infer a latch.
    regs_d = regs_q;
    busy_d = busy_q;

    // Lane 0 first, lane 1 second: on a collision lane 1 overwrites.
    if (wr0) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (wr1) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end

    // Issue applied last: a new producer supersedes the retiring one.
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end

    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the storage array is reset as well as the control state, because
  // architectural registers must read zero out of reset; this keeps the
  // array in flops rather than an inferred RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  function automatic rd_port_t read_port(input logic [AW-1:0] ra);
    rd_port_t res;
    res.data = '0;
    res.busy = 1'b0;
    if (ra != '0) begin
      res.data = regs_q[ra];
      res.busy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if ((wr1 && (wa1 == ra)) || (wr0 && (wa0 == ra))) begin
        res.data = (wr1 && (wa1 == ra)) ? wd1 : wd0;
        // The value being forwarded resolves the pending write, unless a
        // younger producer is issuing to the same register right now.
        if (!(iss_valid && (iss_rd == ra))) begin
          res.busy = 1'b0;
        end
      end
`endif
    end
    return res;
  endfunction

  rd_port_t port1;
  rd_port_t port2;

  always_comb begin
    port1 = '0;
    port2 = '0;
    // Registered state is already zero during reset; the gate additionally
    // keeps forwarded write data off the read ports while rst is high.
    if (!rst) begin
      port1 = read_port(ra1);
      port2 = read_port(ra2);
    end
  end

  assign rd1    = port1.data;
  assign rd2    = port2.data;
  assign busy1  = port1.busy;
  assign busy2  = port2.busy;
  assign hazard = port1.busy | port2.busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            we0;
  logic [AW-1:0]   wa0;
  logic [XLEN-1:0] wd0;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd1;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;
  logic            hazard;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  // ---------------- table-driven vectors ----------------
  // Write/issue fields are applied across one clock edge; afterwards the
  // lanes go idle, ra1/ra2 are set and the expected read values compared.
  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            iv;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] e_rd1;
    logic [XLEN-1:0] e_rd2;
    logic            e_b1;
    logic            e_b2;
    logic            e_hz;
  } vec_t;

  vec_t vecs [10];

  // ---------------- behavioural reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // One clock edge: decide each register's fate from the architectural rules.
  task automatic model_clock();
    for (int r = 1; r < NREGS; r++) begin
      bit hit0 = we0 && (int'(wa0) == r);
      bit hit1 = we1 && (int'(wa1) == r);
      bit iss  = iss_valid && (int'(iss_rd) == r);
      if (hit1)      m_regs[r] = wd1;
      else if (hit0) m_regs[r] = wd0;
      if (iss)                m_busy[r] = 1'b1;
      else if (hit0 || hit1)  m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] ra, output logic [XLEN-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (ra != '0) begin
      d = m_regs[ra];
      b = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
      if ((we1 && wa1 == ra) || (we0 && wa0 == ra)) begin
        d = (we1 && wa1 == ra) ? wd1 : wd0;
        if (!(iss_valid && iss_rd == ra)) b = 1'b0;
      end
`endif
    end
  endtask

  task automatic check_model();
    logic [XLEN-1:0] e1, e2;
    logic b1, b2;
    model_read(ra1, e1, b1);
    model_read(ra2, e2, b2);
    check("rnd_rd1", rd1, e1);
    check("rnd_rd2", rd2, e2);
    check("rnd_busy1", busy1, b1);
    check("rnd_busy2", busy2, b2);
    check("rnd_hazard", hazard, b1 | b2);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    // Half of the addresses come from a small window to force collisions.
    return ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom % NREGS);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  5'd5,  5'd0,  64'h1234, 64'h0,    1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  1'b1, 5'd9,  5'd9,  5'd5,  64'h0,    64'h1234, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  64'hFFFF, 1'b0, 5'd0,  64'h0,  1'b1, 5'd0,  5'd0,  5'd9,  64'h0,    64'h0,    1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 5'd9,  64'h5,    1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  5'd9,  5'd0,  64'h5,    64'h0,    1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd7,  64'h11,   1'b1, 5'd7,  64'h22, 1'b0, 5'd0,  5'd0,  5'd7,  64'h0,    64'h22,   1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  1'b1, 5'd3,  5'd3,  5'd7,  64'h0,    64'h22,   1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd3,  64'hAB, 1'b1, 5'd3,  5'd3,  5'd7,  64'hAB,   64'h22,   1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd3,  64'hCD,   1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  5'd3,  5'd0,  64'hCD,   64'h0,    1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 5'd10, 64'hA0,   1'b1, 5'd11, 64'hB0, 1'b1, 5'd12, 5'd10, 5'd11, 64'hA0,   64'hB0,   1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  5'd12, 5'd10, 64'h0,    64'hA0,   1'b1, 1'b0, 1'b1};

    // ---- reset state ----
    idle();
    ra1 = 5'd5; ra2 = 5'd9;
    rst = 1'b1;
    #12;
    check("reset_rd1", rd1, '0);
    check("reset_busy1", busy1, 1'b0);
    check("reset_hazard", hazard, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      @(posedge clk); #1;
      idle();
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("vec%0d_busy1", i), busy1, vecs[i].e_b1);
      check($sformatf("vec%0d_busy2", i), busy2, vecs[i].e_b2);
      check($sformatf("vec%0d_hazard", i), hazard, vecs[i].e_hz);
    end

    // ---- asynchronous reset with x4 preloaded and x6 busy ----
    we0 = 1'b1; wa0 = 5'd4; wd0 = 64'hDEAD;
    iss_valid = 1'b1; iss_rd = 5'd6;
    @(posedge clk); #1;
    idle();
    ra1 = 5'd4; ra2 = 5'd6;
    #1;
    check("pre_rst_rd1", rd1, 64'hDEAD);
    check("pre_rst_busy2", busy2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rd1", rd1, '0);
    check("async_rst_busy2", busy2, 1'b0);
    check("async_rst_hazard", hazard, 1'b0);
    // Writes attempted while reset is held must not land or forward.
    we0 = 1'b1; wa0 = 5'd4; wd0 = 64'h99;
    #1;
    check("rst_hold_rd1", rd1, '0);
    @(posedge clk); #1;
    check("rst_edge_rd1", rd1, '0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_rd1", rd1, '0);
    check("post_rst_busy2", busy2, 1'b0);

    // ---- same-cycle read during a write of x12 (old 0x10, busy) ----
    we0 = 1'b1; wa0 = 5'd12; wd0 = 64'h10;
    iss_valid = 1'b1; iss_rd = 5'd12;
    @(posedge clk); #1;
    idle();
    we0 = 1'b1; wa0 = 5'd12; wd0 = 64'h77;
    ra1 = 5'd12; ra2 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd1", rd1, 64'h77);
    check("same_cycle_busy1", busy1, 1'b0);
`else
    check("same_cycle_rd1", rd1, 64'h10);
    check("same_cycle_busy1", busy1, 1'b1);
`endif
    @(posedge clk); #1;
    idle();
    #1;
    check("after_write_rd1", rd1, 64'h77);
    check("after_write_busy1", busy1, 1'b0);

    // ---- randomized against the reference model ----
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    repeat (400) begin
      we0 = 1'($urandom % 2); wa0 = rand_addr(); wd0 = {$urandom, $urandom};
      we1 = 1'($urandom % 2); wa1 = rand_addr(); wd1 = {$urandom, $urandom};
      iss_valid = 1'($urandom % 2); iss_rd = rand_addr();
      ra1 = rand_addr(); ra2 = rand_addr();
      #1;
      check_model();
      @(posedge clk);
      model_clock();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
